// File: rtl/anita_multi_buffer_handler.sv
// anita_multi_buffer_handler
//   Purpose : Allocates one of NUM_BUF SURF hold buffers round-robin per accepted
//             trigger, holds it, issues a delayed digitize command and keeps the
//             buffer busy until readout clears it.
//   Latency : HOLD/dead one cycle after the trigger cycle; digitize_o HOLD_DELAY
//             cycles after HOLD rises; dead_o falls HOLDOFF+1 cycles after digitize.
//   Backpressure: dead_o high (engine busy or all buffers busy) drops triggers.
//   Ports   : clk250_i/rst_n_i clock and async active-low reset; disable_i,
//             trig_en_i, trig_i trigger inputs; clear_i/clear_buffer_i buffer
//             release; HOLD_o/buffer_status_o busy bits; digitize_o,
//             digitize_buffer_o, digitize_source_o digitize command; dead_o;
//             dropped_count_o lost-trigger counter.
//   Option  : define ANITA_BUF_DROP_COUNT_EN to build the saturating drop counter;
//             otherwise dropped_count_o is tied to zero.
module anita_multi_buffer_handler #(
  parameter int NUM_BUF    = 4,
  parameter int NUM_TRIG   = 4,
  parameter int HOLD_DELAY = 8,
  parameter int HOLDOFF    = 16,
  parameter int BUF_W      = $clog2(NUM_BUF)
) (
  input  logic                clk250_i,
  input  logic                rst_n_i,
  input  logic                disable_i,
  input  logic [NUM_TRIG-1:0] trig_en_i,
  input  logic [NUM_TRIG-1:0] trig_i,
  input  logic                clear_i,
  input  logic [BUF_W-1:0]    clear_buffer_i,
  output logic [NUM_BUF-1:0]  HOLD_o,
  output logic                digitize_o,
  output logic [BUF_W-1:0]    digitize_buffer_o,
  output logic [NUM_TRIG-1:0] digitize_source_o,
  output logic [NUM_BUF-1:0]  buffer_status_o,
  output logic                dead_o,
  output logic [15:0]         dropped_count_o
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_HOLD_WAIT = 2'd1,
    S_DIGITIZE  = 2'd2,
    S_HOLDOFF   = 2'd3
  } state_t;

  // Counters reload with N-1 so that each timed state lasts exactly N cycles.
  localparam logic [7:0] HOLD_DELAY_M1 = 8'(HOLD_DELAY - 1);
  localparam logic [7:0] HOLDOFF_M1    = 8'(HOLDOFF - 1);

  state_t               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [NUM_BUF-1:0]   busy_q, busy_d;
  logic [NUM_BUF-1:0]   issued_q, issued_d;
  logic [BUF_W-1:0]     ptr_q, ptr_d;
  logic [BUF_W-1:0]     dig_buf_q, dig_buf_d;
  logic [NUM_TRIG-1:0]  dig_src_q, dig_src_d;
  logic                 dig_q, dig_d;

  logic [NUM_TRIG-1:0]  trig_eff;
  logic                 trig_any;
  logic                 dead;
  logic                 accept;
  logic                 clr_ok;
  logic                 free_found;
  logic [BUF_W-1:0]     free_idx;
  logic [BUF_W-1:0]     cand;

  assign trig_eff = disable_i ? '0 : (trig_i & trig_en_i);
  assign trig_any = |trig_eff;

  // Round-robin search: first non-busy buffer at or above ptr_q, wrapping.
  // NUM_BUF is a power of two, so BUF_W-bit addition wraps naturally.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    cand       = '0;
    for (int i = 0; i < NUM_BUF; i++) begin
      cand = ptr_q + BUF_W'(i);
      if (!free_found && !busy_q[cand]) begin
        free_found = 1'b1;
        free_idx   = cand;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM: next state and timer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_HOLD_WAIT;
          cnt_d   = HOLD_DELAY_M1;
        end
      end
      S_HOLD_WAIT: begin
        if (cnt_q == 8'd0) state_d = S_DIGITIZE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_DIGITIZE: begin
        if (HOLDOFF == 0) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLDOFF;
          cnt_d   = HOLDOFF_M1;
        end
      end
      S_HOLDOFF: begin
        if (cnt_q == 8'd0) state_d = S_IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM: outputs decoded from state
  always_comb begin
    dead   = (state_q != S_IDLE) | (&busy_q);
    // Not all busy whenever dead is low, so a free buffer always exists here.
    accept = trig_any & ~dead & free_found;
    dig_d  = (state_d == S_DIGITIZE);
  end

  // Buffer bookkeeping. A buffer can only be released once its digitize
  // command has gone out; clears of idle or still-holding buffers are dropped.
  always_comb begin
    busy_d    = busy_q;
    issued_d  = issued_q;
    ptr_d     = ptr_q;
    dig_buf_d = dig_buf_q;
    dig_src_d = dig_src_q;
    clr_ok    = clear_i & busy_q[clear_buffer_i] & issued_q[clear_buffer_i];

    if (clr_ok) begin
      busy_d[clear_buffer_i]   = 1'b0;
      issued_d[clear_buffer_i] = 1'b0;
    end
    if (state_q == S_DIGITIZE) begin
      issued_d[dig_buf_q] = 1'b1;
    end
    // The allocated buffer was not busy, so it never collides with the clear.
    if (accept) begin
      busy_d[free_idx]   = 1'b1;
      issued_d[free_idx] = 1'b0;
      ptr_d              = free_idx + BUF_W'(1);
      dig_buf_d          = free_idx;
      dig_src_d          = trig_eff;
    end
  end

  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy_q    <= '0;
      issued_q  <= '0;
      ptr_q     <= '0;
      dig_buf_q <= '0;
      dig_src_q <= '0;
      dig_q     <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      issued_q  <= issued_d;
      ptr_q     <= ptr_d;
      dig_buf_q <= dig_buf_d;
      dig_src_q <= dig_src_d;
      dig_q     <= dig_d;
    end
  end

`ifdef ANITA_BUF_DROP_COUNT_EN
  logic [15:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (trig_any && dead && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) drop_q <= '0;
    else          drop_q <= drop_d;
  end

  assign dropped_count_o = drop_q;
`else
  assign dropped_count_o = 16'd0;
`endif

  assign HOLD_o            = busy_q;
  assign buffer_status_o   = busy_q;
  assign digitize_o        = dig_q;
  assign digitize_buffer_o = dig_buf_q;
  assign digitize_source_o = dig_src_q;
  assign dead_o            = dead;

endmodule

// File: tb/tb_anita_multi_buffer_handler.sv
// Bench for anita_multi_buffer_handler at default parameters: directed
// scenarios with constant expectations plus a randomized run checked each
// cycle against a transaction-level model (absolute cycle timestamps).
module tb_anita_multi_buffer_handler;
  localparam int NB = 4;
  localparam int NT = 4;
  localparam int HD = 8;
  localparam int HO = 16;
  localparam int BW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          dis;
  logic [NT-1:0] en;
  logic [NT-1:0] trig;
  logic          clr;
  logic [BW-1:0] cb;
  logic [NB-1:0] hold;
  logic          dig;
  logic [BW-1:0] dig_buf;
  logic [NT-1:0] dig_src;
  logic [NB-1:0] status;
  logic          dead;
  logic [15:0]   drop;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [NB-1:0] m_busy, m_issued;
  int            m_ptr, m_acc, m_drop, cyc;
  bit            m_acc_v;
  logic [BW-1:0] m_buf;
  logic [NT-1:0] m_src;

  always #2 clk = ~clk;

  anita_multi_buffer_handler #(
    .NUM_BUF(NB), .NUM_TRIG(NT), .HOLD_DELAY(HD), .HOLDOFF(HO)
  ) dut (
    .clk250_i(clk), .rst_n_i(rst_n), .disable_i(dis), .trig_en_i(en),
    .trig_i(trig), .clear_i(clr), .clear_buffer_i(cb), .HOLD_o(hold),
    .digitize_o(dig), .digitize_buffer_o(dig_buf), .digitize_source_o(dig_src),
    .buffer_status_o(status), .dead_o(dead), .dropped_count_o(drop)
  );

  function automatic int exp_drop(input int n);
`ifdef ANITA_BUF_DROP_COUNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  // Engine window: from the cycle after acceptance through the last holdoff cycle.
  function automatic bit m_dead();
    return (m_acc_v && cyc >= m_acc + 1 && cyc <= m_acc + 1 + HD + HO) || (&m_busy);
  endfunction

  function automatic bit m_dig();
    return m_acc_v && (cyc == m_acc + 1 + HD);
  endfunction

  task automatic model_reset();
    m_busy = '0; m_issued = '0; m_ptr = 0; m_acc = 0; m_acc_v = 0;
    m_buf = '0; m_src = '0; m_drop = 0; cyc = 0;
  endtask

  // Drive one cycle of inputs at a negedge, advance the model across the
  // posedge, return at the following negedge with strobes released.
  task automatic tick(input logic [NT-1:0] tr, input logic [NT-1:0] e, input logic d,
                      input logic c, input logic [BW-1:0] b);
    logic [NT-1:0] t;
    bit dead_now, dig_now, clr_ok, acc;
    int sel;
    trig = tr; en = e; dis = d; clr = c; cb = b;
    t        = d ? '0 : (tr & e);
    dead_now = m_dead();
    dig_now  = m_dig();
    clr_ok   = c && m_busy[b] && m_issued[b];
    acc      = (|t) && !dead_now;
    sel      = -1;
    for (int i = 0; i < NB; i++) begin
      int idx;
      idx = (m_ptr + i) % NB;
      if (sel < 0 && !m_busy[idx]) sel = idx;
    end
    @(posedge clk);
    if (clr_ok) begin m_busy[b] = 1'b0; m_issued[b] = 1'b0; end
    if (dig_now) m_issued[m_buf] = 1'b1;
    if (acc && sel >= 0) begin
      m_busy[sel] = 1'b1; m_issued[sel] = 1'b0;
      m_buf = sel[BW-1:0]; m_src = t; m_ptr = (sel + 1) % NB;
      m_acc = cyc; m_acc_v = 1;
    end
    if ((|t) && dead_now && m_drop < 65535) m_drop = m_drop + exp_drop(1);
    cyc++;
    @(negedge clk);
    trig = '0; clr = 1'b0; cb = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick('0, en, 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; trig = '0; clr = 1'b0; cb = '0; dis = 1'b0; en = '1;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; trig = 4'hF; en = '1; dis = 1'b0; clr = 1'b1; cb = 2'd1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({hold, status, dig, dig_buf, dig_src, dead, drop} !== '0) begin
      miscompares++;
      $display("FAIL reset_values: hold=%b status=%b dig=%b buf=%0d src=%b dead=%b drop=%0d, want all 0",
               hold, status, dig, dig_buf, dig_src, dead, drop);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    idle(10);
    tick(4'b0001, 4'hF, 1'b0, 1'b0, '0);
    vectors++;
    if (hold !== 4'b0001 || dead !== 1'b1 || dig !== 1'b0) begin
      miscompares++;
      $display("FAIL single_hold: hold=%b dead=%b dig=%b, want 0001/1/0", hold, dead, dig);
    end
    for (int i = 0; i < HD - 1; i++) begin
      tick('0, en, 1'b0, 1'b0, '0);
      vectors++;
      if (dig !== 1'b0) begin
        miscompares++;
        $display("FAIL single_early_dig: step %0d dig=%b, want 0", i, dig);
      end
    end
    tick('0, en, 1'b0, 1'b0, '0);
    vectors++;
    if (dig !== 1'b1 || dig_buf !== 2'd0 || dig_src !== 4'b0001) begin
      miscompares++;
      $display("FAIL single_dig: dig=%b buf=%0d src=%b, want 1/0/0001", dig, dig_buf, dig_src);
    end
    tick('0, en, 1'b0, 1'b0, '0);
    vectors++;
    if (dig !== 1'b0 || dead !== 1'b1) begin
      miscompares++;
      $display("FAIL single_dig_width: dig=%b dead=%b, want 0/1", dig, dead);
    end
    idle(HO - 1);
    vectors++;
    if (dead !== 1'b1) begin
      miscompares++;
      $display("FAIL single_holdoff_end: dead=%b, want 1", dead);
    end
    tick('0, en, 1'b0, 1'b0, '0);
    vectors++;
    if (dead !== 1'b0 || hold !== 4'b0001) begin
      miscompares++;
      $display("FAIL single_dead_fall: dead=%b hold=%b, want 0/0001", dead, hold);
    end
  endtask

  task automatic test_fill();
    for (int k = 1; k < NB; k++) begin
      idle(39);
      tick(4'b0001, 4'hF, 1'b0, 1'b0, '0);
      vectors++;
      if (dig_buf !== k[BW-1:0] || hold !== 4'((1 << (k + 1)) - 1)) begin
        miscompares++;
        $display("FAIL fill_alloc: trigger %0d buf=%0d hold=%b, want buf %0d", k, dig_buf, hold, k);
      end
    end
    idle(39);
    vectors++;
    if (hold !== 4'b1111 || dead !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_full: hold=%b dead=%b, want 1111/1", hold, dead);
    end
    tick(4'b0100, 4'hF, 1'b0, 1'b0, '0);
    idle(HD + 2);
    vectors++;
    if (hold !== 4'b1111 || dead !== 1'b1 || dig_buf !== 2'd3 || drop !== 16'(exp_drop(1))) begin
      miscompares++;
      $display("FAIL fill_fifth: hold=%b dead=%b buf=%0d drop=%0d, want 1111/1/3/%0d",
               hold, dead, dig_buf, drop, exp_drop(1));
    end
  endtask

  task automatic test_clear_realloc();
    tick('0, en, 1'b0, 1'b1, 2'd2);
    vectors++;
    if (hold !== 4'b1011 || dead !== 1'b0) begin
      miscompares++;
      $display("FAIL clear2: hold=%b dead=%b, want 1011/0", hold, dead);
    end
    tick(4'b0010, 4'hF, 1'b0, 1'b0, '0);
    vectors++;
    if (hold !== 4'b1111 || dig_buf !== 2'd2 || dig_src !== 4'b0010) begin
      miscompares++;
      $display("FAIL realloc2: hold=%b buf=%0d src=%b, want 1111/2/0010", hold, dig_buf, dig_src);
    end
    idle(30);
    // Trigger in the same cycle as the clear must not see the freed buffer.
    tick(4'b0001, 4'hF, 1'b0, 1'b1, 2'd0);
    vectors++;
    if (hold !== 4'b1110 || drop !== 16'(exp_drop(2)) || dead !== 1'b0) begin
      miscompares++;
      $display("FAIL clear0_same_cycle: hold=%b drop=%0d dead=%b, want 1110/%0d/0",
               hold, drop, dead, exp_drop(2));
    end
    tick(4'b0001, 4'hF, 1'b0, 1'b0, '0);
    vectors++;
    if (hold !== 4'b1111 || dig_buf !== 2'd0) begin
      miscompares++;
      $display("FAIL realloc0: hold=%b buf=%0d, want 1111/0", hold, dig_buf);
    end
  endtask

  task automatic test_mask();
    do_reset();
    tick(4'b1010, 4'b0010, 1'b0, 1'b0, '0);
    idle(HD);
    vectors++;
    if (dig !== 1'b1 || dig_src !== 4'b0010 || hold !== 4'b0001) begin
      miscompares++;
      $display("FAIL mask_src: dig=%b src=%b hold=%b, want 1/0010/0001", dig, dig_src, hold);
    end
    // In holdoff: masked and disabled triggers are not counted, enabled one is.
    tick(4'b1000, 4'b0010, 1'b0, 1'b0, '0);
    tick(4'b0001, 4'hF, 1'b1, 1'b0, '0);
    vectors++;
    if (drop !== 16'd0) begin
      miscompares++;
      $display("FAIL mask_nocount: drop=%0d, want 0", drop);
    end
    tick(4'b0001, 4'hF, 1'b0, 1'b0, '0);
    vectors++;
    if (drop !== 16'(exp_drop(1))) begin
      miscompares++;
      $display("FAIL mask_count: drop=%0d, want %0d", drop, exp_drop(1));
    end
    idle(30);
    tick(4'b1000, 4'b0010, 1'b0, 1'b0, '0);
    tick(4'b0001, 4'hF, 1'b1, 1'b0, '0);
    vectors++;
    if (hold !== 4'b0001 || dead !== 1'b0 || dig_src !== 4'b0010 || drop !== 16'(exp_drop(1))) begin
      miscompares++;
      $display("FAIL mask_ignored: hold=%b dead=%b src=%b drop=%0d, want 0001/0/0010/%0d",
               hold, dead, dig_src, drop, exp_drop(1));
    end
  endtask

  task automatic test_clear_during_hold();
    do_reset();
    tick(4'b0001, 4'hF, 1'b0, 1'b0, '0);
    idle(30);
    tick('0, en, 1'b0, 1'b1, 2'd0);
    tick(4'b0100, 4'hF, 1'b0, 1'b0, '0);
    tick('0, en, 1'b0, 1'b1, 2'd1);
    vectors++;
    if (hold !== 4'b0010) begin
      miscompares++;
      $display("FAIL clr_in_hold: hold=%b, want 0010", hold);
    end
    idle(HD - 1);
    vectors++;
    if (dig !== 1'b1 || dig_buf !== 2'd1 || dig_src !== 4'b0100) begin
      miscompares++;
      $display("FAIL clr_in_hold_dig: dig=%b buf=%0d src=%b, want 1/1/0100", dig, dig_buf, dig_src);
    end
    idle(5);
    tick('0, en, 1'b0, 1'b1, 2'd1);
    vectors++;
    if (hold !== 4'b0000) begin
      miscompares++;
      $display("FAIL clr_after_dig: hold=%b, want 0000", hold);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(4'b0100, 4'hF, 1'b0, 1'b0, '0);
    idle(3);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({hold, status, dig, dig_buf, dig_src, dead, drop} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: hold=%b status=%b dig=%b buf=%0d src=%b dead=%b drop=%0d, want all 0",
               hold, status, dig, dig_buf, dig_src, dead, drop);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < HD + HO + 4; i++) begin
      tick('0, en, 1'b0, 1'b0, '0);
      vectors++;
      if (dig !== 1'b0 || hold !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_mid_stale: step %0d dig=%b hold=%b, want 0/0000", i, dig, hold);
      end
    end
    tick(4'b0001, 4'hF, 1'b0, 1'b0, '0);
    vectors++;
    if (hold !== 4'b0001 || dig_buf !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_mid_alloc: hold=%b buf=%0d, want 0001/0", hold, dig_buf);
    end
  endtask

  task automatic test_random();
    logic [NT-1:0] r_tr, r_en;
    logic          r_dis, r_clr;
    logic [BW-1:0] r_cb;
    logic [39:0]   act, exp;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r_tr  = ($urandom_range(0, 3) == 0) ? NT'($urandom) : '0;
      r_en  = ($urandom_range(0, 3) == 0) ? NT'($urandom) : '1;
      r_dis = ($urandom_range(0, 9) == 0);
      r_clr = ($urandom_range(0, 5) == 0);
      r_cb  = BW'($urandom);
      tick(r_tr, r_en, r_dis, r_clr, r_cb);
      act = {hold, status, dig, dig_buf, dig_src, dead, drop};
      exp = {m_busy, m_busy, m_dig(), m_buf, m_src, m_dead(), 16'(m_drop)};
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL random_cycle %0d: got %h, want %h (hold,status,dig,buf,src,dead,drop)", i, act, exp);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; trig = '0; en = '1; dis = 1'b0; clr = 1'b0; cb = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_single();
    test_fill();
    test_clear_realloc();
    test_mask();
    test_clear_during_hold();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
